gsm_symbol_upsampler: RTL and testbench
=======================================

// Module: gsm_symbol_upsampler
// PURPOSE
//  Upstream feeder for the time-shared 101-tap symmetric pulse-shaping FIR.
//  - Accepts 2-bit 4-ASK symbols over a valid/ready handshake and Gray-maps them to 1s17 levels.
//  - Zero-stuffs by UPSAMPLE and presents one sample per sam_clk_en on x_out, which drives the FIR x_in.
//  - Emits sym_clk_en on symbol slots; flags and counts underflow when no symbol is ready.
// PARAMETERS
//  WIDTH     18      sample width, 1s17
//  UPSAMPLE  4       samples per symbol (>=2); phase counter width = $clog2(UPSAMPLE)
//  LEVEL_A   32768   inner level magnitude (0.25 in 1s17)
//  LEVEL_B   98304   outer level magnitude (0.75 in 1s17)
//  CNT_W     16      underflow counter width
// PORTS
//  sys_clk        in   1       system clock, all logic rising-edge
//  reset_n        in   1       synchronous active-low reset
//  sam_clk_en     in   1       one-cycle sample-rate enable (same strobe the FIR uses)
//  sym_in         in   2       symbol bits
//  sym_valid      in   1       sym_in valid
//  sym_ready      out  1       block can accept sym_in this cycle
//  x_out          out  WIDTH   signed 1s17 upsampled sample to FIR x_in
//  sym_clk_en     out  1       registered pulse: x_out just loaded a symbol slot
//  underflow      out  1       registered pulse: symbol slot found buffer empty
//  underflow_cnt  out  CNT_W   saturating count of underflow events
// BEHAVIOUR
//  Reset (reset_n==0 at edge): phase=0, buffer empty, x_out=0, sym_clk_en=0, underflow=0,
//   underflow_cnt=0. sym_ready=0 while reset_n==0. Reset wins over every other event.
//   A held symbol is discarded on reset mid-stream.
//  Buffer: one-entry holding reg (buf_data, buf_full).
//   slot     = sam_clk_en && phase==0
//   consume  = slot && buf_full
//   sym_ready = reset_n && (!buf_full || consume)   (combinational)
//   accept   = sym_valid && sym_ready
//   accept and consume in the same cycle: buf_data <= sym_in, buf_full stays 1; old symbol goes to x_out.
//   accept alone sets buf_full; consume alone clears it.
//  Phase counter: advances only on sam_clk_en, UPSAMPLE-1 wraps to 0; holds otherwise.
//  Gray map: 2'b00 -> -LEVEL_B, 2'b01 -> -LEVEL_A, 2'b11 -> +LEVEL_A, 2'b10 -> +LEVEL_B.
//   All values are exact in 18-bit two's complement with no saturation logic.
//  On sam_clk_en:
//   phase==0, buf_full   x_out <= map(buf_data), sym_clk_en <= 1
//   phase==0, !buf_full  x_out <= 0, underflow <= 1, underflow_cnt += 1 (saturates at all-ones)
//   phase!=0             x_out <= 0
//  Without sam_clk_en: x_out holds; sym_clk_en and underflow are 0.
//  Latency: a symbol accepted at edge t appears on x_out at the first slot edge after t.
//   With a continuous source, output is 1 symbol then UPSAMPLE-1 zeros, period UPSAMPLE*sam period.
//  sym_valid may rise or fall at any time; sym_in is sampled only on accept.
//  No combinational path from sym_valid to sym_ready.
// TESTING
//  1 Reset: hold reset_n=0 for 3 clocks with sym_valid=1.
//    -> sym_ready=0, x_out=0, underflow_cnt=0; after release, first accept on the next clock.
//  2 Mapping: send 00, 01, 11, 10 back-to-back with sam_clk_en every 4 clocks.
//    -> x_out slot values -98304, -32768, 32768, 98304, each followed by 3 zeros.
//    -> sym_clk_en pulses once per symbol.
//  3 Underflow: sym_valid=0 for 2 full symbol periods.
//    -> 2 underflow pulses, underflow_cnt=2, x_out=0 throughout.
//    -> next valid symbol is output at the following slot.
//  4 Simultaneous accept/consume: hold sym_valid=1 with ready-to-slot alignment.
//    -> sym_ready stays 1 on slot cycles, no symbol dropped or duplicated over 64 symbols.
//    -> compare against a reference queue.
//  5 Backpressure: buffer full, no slot.
//    -> sym_ready=0; sym_in changes while stalled are ignored; the held value is output.
//  6 Saturation/reset mid-stream: with CNT_W=4, force 20 underflows -> underflow_cnt=15.
//    -> a reset_n pulse mid-period clears count, phase and buffer; sequence restarts at phase 0.

Source files
------------

// File: rtl/gsm_symbol_upsampler.sv
// gsm_symbol_upsampler
// Upstream feeder for the time-shared symmetric pulse-shaping FIR. Takes 2-bit
// 4-ASK symbols over valid/ready, Gray-maps them to signed 1s17 levels and
// zero-stuffs them by UPSAMPLE, presenting one sample per sam_clk_en on x_out.
// Symbol slots with no buffered symbol are flagged and counted as underflows.
//
// Ports
//   sys_clk        in   system clock, all logic on the rising edge
//   reset_n        in   synchronous active-low reset
//   sam_clk_en     in   one-cycle sample-rate enable shared with the FIR
//   sym_in         in   2-bit symbol
//   sym_valid      in   sym_in valid
//   sym_ready      out  symbol can be accepted this cycle (combinational)
//   x_out          out  signed upsampled sample to FIR x_in
//   sym_clk_en     out  pulse: x_out was just loaded with a symbol slot
//   underflow      out  pulse: a symbol slot found the buffer empty
//   underflow_cnt  out  saturating count of underflow events
module gsm_symbol_upsampler #(
  parameter int unsigned WIDTH    = 18,
  parameter int unsigned UPSAMPLE = 4,
  parameter int unsigned LEVEL_A  = 32768,
  parameter int unsigned LEVEL_B  = 98304,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    sam_clk_en,
  input  logic [1:0]              sym_in,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic                    sym_clk_en,
  output logic                    underflow,
  output logic [CNT_W-1:0]        underflow_cnt
);

  localparam int unsigned PH_W = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(UPSAMPLE - 1);
  localparam logic signed [WIDTH-1:0] LVL_A = WIDTH'(LEVEL_A);
  localparam logic signed [WIDTH-1:0] LVL_B = WIDTH'(LEVEL_B);

  logic [PH_W-1:0]         phase;
  logic [1:0]              buf_data;
  logic                    buf_full;
  logic                    slot;
  logic                    consume;
  logic                    accept;
  logic signed [WIDTH-1:0] mapped;

  // Handshake: a slot that drains the buffer frees it for a same-cycle accept,
  // so a continuous source never sees a bubble. sym_valid is not in this path.
  always_comb begin
    slot      = sam_clk_en && (phase == '0);
    consume   = slot && buf_full;
    sym_ready = reset_n && (!buf_full || consume);
    accept    = sym_valid && sym_ready;
  end

  // Gray map of the held symbol to its signed level
  always_comb begin
    mapped = '0;
    case (buf_data)
      2'b00:   mapped = -LVL_B;
      2'b01:   mapped = -LVL_A;
      2'b11:   mapped = LVL_A;
      2'b10:   mapped = LVL_B;
      default: mapped = '0;
    endcase
  end

  // Phase counter, holding buffer and registered sample/status outputs
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      phase         <= '0;
      buf_data      <= '0;
      buf_full      <= 1'b0;
      x_out         <= '0;
      sym_clk_en    <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      sym_clk_en <= 1'b0;
      underflow  <= 1'b0;

      if (sam_clk_en) begin
        phase <= (phase == PH_LAST) ? '0 : PH_W'(phase + 1'b1);
        if (phase != '0) begin
          x_out <= '0;
        end else if (buf_full) begin
          x_out      <= mapped;
          sym_clk_en <= 1'b1;
        end else begin
          x_out     <= '0;
          underflow <= 1'b1;
          if (underflow_cnt != '1) begin
            underflow_cnt <= CNT_W'(underflow_cnt + 1'b1);
          end
        end
      end

      // Accept takes priority: on a simultaneous consume the buffer stays full
      if (accept) begin
        buf_data <= sym_in;
        buf_full <= 1'b1;
      end else if (consume) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gsm_symbol_upsampler.sv
// Bench for gsm_symbol_upsampler (UPSAMPLE=4, CNT_W=4 so saturation is reachable).
// A negedge monitor keeps a symbol queue plus phase count and checks every
// registered output and sym_ready each cycle; directed sequences cover the
// reset, mapping, underflow, streaming, backpressure and saturation cases.
module tb_gsm_symbol_upsampler;

  localparam int unsigned WIDTH = 18;
  localparam int unsigned UPS   = 4;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = 15;

  logic                    sys_clk = 1'b0;
  logic                    reset_n;
  logic                    sam_clk_en;
  logic [1:0]              sym_in;
  logic                    sym_valid;
  logic                    sym_ready;
  logic signed [WIDTH-1:0] x_out;
  logic                    sym_clk_en;
  logic                    underflow;
  logic [CNT_W-1:0]        underflow_cnt;

  gsm_symbol_upsampler #(
    .WIDTH(WIDTH), .UPSAMPLE(UPS), .LEVEL_A(32768), .LEVEL_B(98304), .CNT_W(CNT_W)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .sam_clk_en(sam_clk_en),
    .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .x_out(x_out), .sym_clk_en(sym_clk_en), .underflow(underflow),
    .underflow_cnt(underflow_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int lvl(input logic [1:0] s);
    case (s)
      2'b00:   return -98304;
      2'b01:   return -32768;
      2'b11:   return 32768;
      default: return 98304;
    endcase
  endfunction

  // Scoreboard monitor: predicts the next edge's outputs from the symbols
  // offered and the sample strobes seen, compares one cycle later.
  int mq[$];
  int mph = 0;
  int px = 0, psce = 0, puf = 0, pcnt = 0;
  bit have_pred = 1'b0;

  always @(negedge sys_clk) begin
    int exp_rdy;
    if (have_pred) begin
      chk("mon_x_out", int'(x_out), px);
      chk("mon_sym_clk_en", int'(sym_clk_en), psce);
      chk("mon_underflow", int'(underflow), puf);
      chk("mon_underflow_cnt", int'(underflow_cnt), pcnt);
    end
    exp_rdy = (reset_n && (mq.size() == 0 || (sam_clk_en && mph == 0))) ? 1 : 0;
    chk("mon_sym_ready", int'(sym_ready), exp_rdy);
    if (!reset_n) begin
      mph = 0; mq.delete(); px = 0; psce = 0; puf = 0; pcnt = 0;
    end else begin
      psce = 0; puf = 0;
      if (sam_clk_en) begin
        if (mph == 0) begin
          if (mq.size() > 0) begin
            px = mq.pop_front(); psce = 1;
          end else begin
            px = 0; puf = 1;
            if (pcnt < CMAX) pcnt++;
          end
        end else begin
          px = 0;
        end
        mph = (mph + 1) % UPS;
      end
      if (sym_valid && exp_rdy == 1) mq.push_back(lvl(sym_in));
    end
    have_pred = 1'b1;
  end

  // Stimulus helpers
  bit sam_auto = 1'b0;
  int spd = 4;
  int sdiv = 0;
  bit acc;
  bit rdy_seen;

  // One clock: called at posedge+1, inputs already set; returns at next posedge+1
  task automatic clk_cycle();
    if (sam_auto) begin
      sam_clk_en = ((sdiv % spd) == 0);
      sdiv++;
    end
    #2;
    rdy_seen = sym_ready;
    acc = sym_valid && sym_ready && reset_n;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sam_auto = 1'b0; sam_clk_en = 1'b0; sym_valid = 1'b0; reset_n = 1'b0;
    repeat (2) clk_cycle();
    reset_n = 1'b1; sdiv = 0; sam_auto = 1'b1;
  endtask

  typedef struct {
    logic [1:0] sym;
    int         exp;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int k, o, ucount, zbad, outs;
    int rq[$];
    bit got_out;

    reset_n = 1'b0; sam_clk_en = 1'b0; sym_in = 2'b00; sym_valid = 1'b1;
    tbl[0] = '{2'b00, -98304};
    tbl[1] = '{2'b01, -32768};
    tbl[2] = '{2'b11, 32768};
    tbl[3] = '{2'b10, 98304};
    @(posedge sys_clk); #1;

    // 1: reset held with valid asserted, first accept right after release
    for (int i = 0; i < 3; i++) begin
      clk_cycle();
      chk("rst_ready", int'(rdy_seen), 0);
      chk("rst_x_out", int'(x_out), 0);
      chk("rst_cnt", int'(underflow_cnt), 0);
    end
    reset_n = 1'b1;
    clk_cycle();
    chk("rst_first_accept", int'(acc), 1);
    clk_cycle();
    chk("rst_full_no_ready", int'(rdy_seen), 0);
    sym_valid = 1'b0;

    // 2: Gray mapping, back-to-back symbols, sample strobe every 4 clocks
    do_reset(); spd = 4;
    k = 0; o = 0;
    for (int c = 0; c < 200 && o < 4; c++) begin
      sym_valid = (k < 4);
      sym_in = (k < 4) ? tbl[k].sym : 2'b00;
      clk_cycle();
      if (acc) k++;
      if (sym_clk_en) begin
        if (o < 4) chk("map_level", int'(x_out), tbl[o].exp);
        o++;
      end
    end
    sym_valid = 1'b0;
    chk("map_pulses", o, 4);

    // 3: underflow over two symbol periods, then recovery
    do_reset(); spd = 4;
    ucount = 0; zbad = 0;
    for (int c = 0; c < 30; c++) begin
      clk_cycle();
      if (underflow) ucount++;
      if (x_out != 0) zbad++;
    end
    chk("uf_pulses", ucount, 2);
    chk("uf_cnt", int'(underflow_cnt), 2);
    chk("uf_zero_out", zbad, 0);
    sym_valid = 1'b1; sym_in = 2'b11;
    got_out = 1'b0;
    for (int c = 0; c < 10 && !got_out; c++) begin
      clk_cycle();
      if (acc) sym_valid = 1'b0;
      if (sym_clk_en) begin
        got_out = 1'b1;
        chk("uf_recover_level", int'(x_out), 32768);
      end
    end
    chk("uf_recover_seen", int'(got_out), 1);
    chk("uf_cnt_after", int'(underflow_cnt), 2);

    // 4: continuous source, strobe every clock, 64 symbols against a reference queue
    do_reset(); spd = 1;
    sym_valid = 1'b1; outs = 0;
    for (int c = 0; c < 400 && outs < 64; c++) begin
      sym_in = 2'($urandom_range(0, 3));
      clk_cycle();
      if (acc) rq.push_back(lvl(sym_in));
      if (sym_clk_en) begin
        if (rq.size() == 0) chk("stream_unexpected_out", 1, 0);
        else chk("stream_level", int'(x_out), rq.pop_front());
        outs++;
      end
    end
    sym_valid = 1'b0;
    chk("stream_count", outs, 64);
    chk("stream_no_underflow", int'(underflow_cnt), 1);

    // 5: backpressure, buffer full with no slot
    do_reset(); sam_auto = 1'b0; sam_clk_en = 1'b0;
    sym_valid = 1'b1; sym_in = 2'b01;
    clk_cycle();
    chk("bp_accept", int'(acc), 1);
    sym_in = 2'b10;
    for (int i = 0; i < 3; i++) begin
      clk_cycle();
      chk("bp_stall_ready", int'(rdy_seen), 0);
      sym_in = ~sym_in;
    end
    sym_valid = 1'b0; sam_clk_en = 1'b1;
    clk_cycle();
    chk("bp_sce", int'(sym_clk_en), 1);
    chk("bp_held_level", int'(x_out), -32768);
    sam_clk_en = 1'b0;

    // 6: counter saturation, then reset mid-period with a symbol held
    do_reset(); spd = 1;
    ucount = 0;
    for (int c = 0; c < 80; c++) begin
      clk_cycle();
      if (underflow) ucount++;
    end
    chk("sat_pulses", ucount, 20);
    chk("sat_cnt", int'(underflow_cnt), CMAX);
    clk_cycle();
    chk("sat_hold_pulse", int'(underflow), 1);
    chk("sat_hold_cnt", int'(underflow_cnt), CMAX);
    sym_valid = 1'b1; sym_in = 2'b10;
    clk_cycle();
    chk("mid_accept", int'(acc), 1);
    sym_valid = 1'b0; reset_n = 1'b0;
    clk_cycle();
    chk("mid_rst_cnt", int'(underflow_cnt), 0);
    chk("mid_rst_x", int'(x_out), 0);
    reset_n = 1'b1;
    clk_cycle();
    chk("restart_underflow", int'(underflow), 1);
    chk("restart_no_sym", int'(sym_clk_en), 0);
    chk("restart_cnt", int'(underflow_cnt), 1);

    sam_auto = 1'b0; sam_clk_en = 1'b0;
    repeat (2) clk_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
